pulse_seq_ctrl: RTL and testbench

PULSE_SEQ_CTRL -- requirements
Module: pulse_seq_ctrl

---
 rtl/pulse_seq_pkg.sv | 24 ++
 rtl/pulse_seq_timer.sv | 28 ++
 rtl/pulse_seq_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_pulse_seq_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_seq_pkg.sv
// rtl/pulse_seq_pkg.sv - shared states, register map and reset defaults for the pulse sequencer
package pulse_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P1   = 3'd1,
    ST_GAP  = 3'd2,
    ST_P2   = 3'd3,
    ST_WAIT = 3'd4
  } state_t;

  localparam logic [2:0] ADDR_WIDTH1  = 3'd0;
  localparam logic [2:0] ADDR_DELAY   = 3'd1;
  localparam logic [2:0] ADDR_WIDTH2  = 3'd2;
  localparam logic [2:0] ADDR_PERIOD  = 3'd3;
  localparam logic [2:0] ADDR_REPEATS = 3'd4;

  localparam int unsigned RST_WIDTH1  = 30;
  localparam int unsigned RST_DELAY   = 200;
  localparam int unsigned RST_WIDTH2  = 60;
  localparam int unsigned RST_PERIOD  = 200000;
  localparam int unsigned RST_REPEATS = 0;

endpackage

// File: rtl/pulse_seq_timer.sv
// rtl/pulse_seq_timer.sv - loadable down-counter with zero flag, reloaded at every phase change
module pulse_seq_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load wins over counting; the counter parks at zero until reloaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pulse_seq_ctrl.sv
// rtl/pulse_seq_ctrl.sv - repeating two-pulse sequencer; optional sync output under PULSE_SEQ_SYNC_EN
module pulse_seq_ctrl
  import pulse_seq_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int REP_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_wdata,
  input  logic             start,
  input  logic             stop,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] rep_cnt
`ifdef PULSE_SEQ_SYNC_EN
  ,
  output logic             sync
`endif
);

  localparam int XW = CNT_W + 2;

  state_t state, state_nx, first_st, follow_st;

  logic [CNT_W-1:0] cfg_w1, cfg_dly, cfg_w2, cfg_per;
  logic [REP_W-1:0] cfg_rep;
  logic [CNT_W-1:0] sh_w1, sh_dly, sh_w2, sh_per;
  logic [REP_W-1:0] sh_rep;

  logic [CNT_W-1:0] src_w1, src_dly, src_w2, src_per, len_wt, nx_len;
  logic [REP_W-1:0] src_rep, rep_plus;
  logic [XW-1:0]    sum_x, per_x, wait_x;

  logic tmr_load, tmr_zero, run_start, period_start, rep_inc, done_nx, last_phase;

  // In IDLE the live registers decide the first phase; during a run the shadows do.
  assign src_w1  = (state == ST_IDLE) ? cfg_w1  : sh_w1;
  assign src_dly = (state == ST_IDLE) ? cfg_dly : sh_dly;
  assign src_w2  = (state == ST_IDLE) ? cfg_w2  : sh_w2;
  assign src_per = (state == ST_IDLE) ? cfg_per : sh_per;
  assign src_rep = (state == ST_IDLE) ? cfg_rep : sh_rep;
  assign rep_plus = rep_cnt + REP_W'(1);

  assign sum_x  = {2'b00, src_w1} + {2'b00, src_dly} + {2'b00, src_w2};
  assign per_x  = {2'b00, src_per};
  assign wait_x = (per_x > sum_x) ? (per_x - sum_x) : '0;

  // WAIT fills the rest of the period; an all-zero period still lasts one cycle in WAIT.
  always_comb begin
    len_wt = wait_x[CNT_W-1:0];
    if ((sum_x == '0) && (wait_x == '0)) begin
      len_wt = CNT_W'(1);
    end
  end

  // First non-empty phase of a period; WAIT always exists when the pulses are all empty.
  always_comb begin
    first_st = ST_WAIT;
    if (src_w1 != '0) begin
      first_st = ST_P1;
    end else if (src_dly != '0) begin
      first_st = ST_GAP;
    end else if (src_w2 != '0) begin
      first_st = ST_P2;
    end
  end

  // Successor of the current phase, skipping empty phases; last_phase marks end of period.
  always_comb begin
    follow_st  = ST_IDLE;
    last_phase = 1'b0;
    case (state)
      ST_P1: begin
        if (src_dly != '0)     follow_st = ST_GAP;
        else if (src_w2 != '0) follow_st = ST_P2;
        else if (len_wt != '0) follow_st = ST_WAIT;
        else                   last_phase = 1'b1;
      end
      ST_GAP: begin
        if (src_w2 != '0)      follow_st = ST_P2;
        else if (len_wt != '0) follow_st = ST_WAIT;
        else                   last_phase = 1'b1;
      end
      ST_P2: begin
        if (len_wt != '0)      follow_st = ST_WAIT;
        else                   last_phase = 1'b1;
      end
      ST_WAIT: last_phase = 1'b1;
      default: ;
    endcase
  end

  // Next-state decision: start from IDLE, abort on stop, advance on timer expiry.
  always_comb begin
    state_nx     = state;
    tmr_load     = 1'b0;
    run_start    = 1'b0;
    period_start = 1'b0;
    rep_inc      = 1'b0;
    done_nx      = 1'b0;
    if (state == ST_IDLE) begin
      if (start && !stop) begin
        run_start    = 1'b1;
        period_start = 1'b1;
        tmr_load     = 1'b1;
        state_nx     = first_st;
      end
    end else if (stop) begin
      state_nx = ST_IDLE;
    end else if (tmr_zero) begin
      tmr_load = 1'b1;
      if (!last_phase) begin
        state_nx = follow_st;
      end else begin
        rep_inc = 1'b1;
        if ((src_rep != '0) && (rep_plus == src_rep)) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
          tmr_load = 1'b0;
        end else begin
          state_nx     = first_st;
          period_start = 1'b1;
        end
      end
    end
  end

  // Length of the phase being entered; the timer holds length-1 so zero marks the last cycle.
  always_comb begin
    nx_len = CNT_W'(1);
    case (state_nx)
      ST_P1:   nx_len = src_w1;
      ST_GAP:  nx_len = src_dly;
      ST_P2:   nx_len = src_w2;
      ST_WAIT: nx_len = len_wt;
      default: ;
    endcase
  end

  pulse_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (1'b1),
    .load_val (nx_len - CNT_W'(1)),
    .zero     (tmr_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Config registers accept writes only while idle; reserved addresses are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_w1  <= CNT_W'(RST_WIDTH1);
      cfg_dly <= CNT_W'(RST_DELAY);
      cfg_w2  <= CNT_W'(RST_WIDTH2);
      cfg_per <= CNT_W'(RST_PERIOD);
      cfg_rep <= REP_W'(RST_REPEATS);
    end else if (cfg_we && (state == ST_IDLE)) begin
      case (cfg_addr)
        ADDR_WIDTH1:  cfg_w1  <= cfg_wdata;
        ADDR_DELAY:   cfg_dly <= cfg_wdata;
        ADDR_WIDTH2:  cfg_w2  <= cfg_wdata;
        ADDR_PERIOD:  cfg_per <= cfg_wdata;
        ADDR_REPEATS: cfg_rep <= cfg_wdata[REP_W-1:0];
        default: ;
      endcase
    end
  end

  // Shadow copies freeze the configuration for the duration of a run.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_w1  <= '0;
      sh_dly <= '0;
      sh_w2  <= '0;
      sh_per <= '0;
      sh_rep <= '0;
    end else if (run_start) begin
      sh_w1  <= cfg_w1;
      sh_dly <= cfg_dly;
      sh_w2  <= cfg_w2;
      sh_per <= cfg_per;
      sh_rep <= cfg_rep;
    end
  end

  // Registered outputs follow the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      out     <= 1'b0;
      done    <= 1'b0;
      rep_cnt <= '0;
    end else begin
      out  <= (state_nx == ST_P1) || (state_nx == ST_P2);
      done <= done_nx;
      if (run_start)    rep_cnt <= '0;
      else if (rep_inc) rep_cnt <= rep_plus;
    end
  end

`ifdef PULSE_SEQ_SYNC_EN
  // Sync marks the first cycle of every period.
  always_ff @(posedge clk) begin
    if (rst) sync <= 1'b0;
    else     sync <= period_start;
  end
`else
  logic unused_period_start;
  assign unused_period_start = period_start;
`endif

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// tb/tb_pulse_seq_ctrl.sv - scoreboard bench for pulse_seq_ctrl against a per-cycle period model
module tb_pulse_seq_ctrl;

  localparam int CW = 32;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_addr = '0;
  logic [CW-1:0] cfg_wdata = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          out, busy, done;
  logic [RW-1:0] rep_cnt;
`ifdef PULSE_SEQ_SYNC_EN
  logic          sync;
`endif

  pulse_seq_ctrl #(.CNT_W(CW), .REP_W(RW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .start     (start),
    .stop      (stop),
    .out       (out),
    .busy      (busy),
    .done      (done),
`ifdef PULSE_SEQ_SYNC_EN
    .sync      (sync),
`endif
    .rep_cnt   (rep_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int            cyc;
    logic          out;
    logic          busy;
    logic          done;
    logic          sync;
    logic [RW-1:0] rep;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  int m_w1 = 30, m_d = 200, m_w2 = 60, m_per = 200000, m_rep = 0;
  int m_last_rep = 0;

  // Expected outputs k cycles after the start was sampled, from the period rules.
  function automatic exp_t model_at(int k);
    exp_t e;
    int sum, len, total, p, o;
    sum = m_w1 + m_d + m_w2;
    len = sum;
    if (m_per > len) len = m_per;
    if (len < 1) len = 1;
    total = m_rep * len;
    e.cyc = 0;
    if ((m_rep != 0) && (k > total)) begin
      e.out = 1'b0; e.busy = 1'b0; e.done = (k == total + 1); e.sync = 1'b0;
      e.rep = m_rep[RW-1:0];
    end else begin
      p = (k - 1) / len;
      o = (k - 1) % len;
      e.out  = (o < m_w1) || ((o >= m_w1 + m_d) && (o < sum));
      e.busy = 1'b1;
      e.done = 1'b0;
      e.sync = (o == 0);
      e.rep  = RW'(p % (1 << RW));
    end
    return e;
  endfunction

  function automatic exp_t idle_exp(int at, int rep);
    exp_t e;
    e.cyc = at; e.out = 1'b0; e.busy = 1'b0; e.done = 1'b0; e.sync = 1'b0;
    e.rep = RW'(rep);
    return e;
  endfunction

  // Monitor: compare the DUT against the oldest expectation due this cycle.
  always @(negedge clk) begin
    exp_t e;
    if ((sb.size() > 0) && (sb[0].cyc == cyc)) begin
      e = sb.pop_front();
      checks++;
      if ({out, busy, done, rep_cnt} !== {e.out, e.busy, e.done, e.rep}) begin
        failures++;
        $display("FAIL outputs cyc=%0d got out=%b busy=%b done=%b rep=%0d expected out=%b busy=%b done=%b rep=%0d",
                 cyc, out, busy, done, rep_cnt, e.out, e.busy, e.done, e.rep);
      end
`ifdef PULSE_SEQ_SYNC_EN
      checks++;
      if (sync !== e.sync) begin
        failures++;
        $display("FAIL sync cyc=%0d got %b expected %b", cyc, sync, e.sync);
      end
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(int a, int d, bit dut_busy);
    cfg_we = 1'b1; cfg_addr = a[2:0]; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
    if (!dut_busy) begin
      case (a)
        0: m_w1 = d;
        1: m_d = d;
        2: m_w2 = d;
        3: m_per = d;
        4: m_rep = d % (1 << RW);
        default: ;
      endcase
    end
  endtask

  task automatic cfg_all(int w1, int d, int w2, int per, int reps);
    cfg_write(0, w1, 1'b0);
    cfg_write(1, d, 1'b0);
    cfg_write(2, w2, 1'b0);
    cfg_write(3, per, 1'b0);
    cfg_write(4, reps, 1'b0);
  endtask

  // Start a run; stop_k>0 aborts after that many cycles, wr_k>0 writes DELAY mid-run.
  task automatic run(int stop_k, int wr_k);
    int base, total, sum, len, stop_rep;
    exp_t e;
    base = cyc;
    sum = m_w1 + m_d + m_w2;
    len = (sum > m_per) ? sum : m_per;
    if (len < 1) len = 1;
    total = m_rep * len;
    stop_rep = 0;
    if (stop_k > 0) begin
      for (int k = 1; k <= stop_k; k++) begin
        e = model_at(k); e.cyc = base + k; sb.push_back(e);
      end
      stop_rep = int'(model_at(stop_k).rep);
      sb.push_back(idle_exp(base + stop_k + 1, stop_rep));
      sb.push_back(idle_exp(base + stop_k + 2, stop_rep));
    end else begin
      for (int k = 1; k <= total + 2; k++) begin
        e = model_at(k); e.cyc = base + k; sb.push_back(e);
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    if (stop_k > 0) begin
      while (cyc < base + stop_k) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tick();
      m_last_rep = stop_rep;
    end else begin
      while (cyc < base + total + 2) begin
        if ((wr_k > 0) && (cyc == base + wr_k)) cfg_write(1, 5, 1'b1);
        else tick();
      end
      m_last_rep = m_rep;
    end
  endtask

  initial begin
    int rk, base;
    exp_t e;
    sb.push_back(idle_exp(2, 0));
    sb.push_back(idle_exp(3, 0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Reset defaults: 30 high, 200 low, 60 high, then long WAIT.
    run(300, 0);

    // Basic 10-cycle period, three repeats then done.
    cfg_all(2, 3, 1, 10, 3);
    run(0, 0);

    // Period stretched to the pulse sum.
    cfg_all(4, 4, 4, 5, 1);
    run(0, 0);

    // Empty gap merges the pulses; a busy write to DELAY must not land.
    cfg_all(2, 0, 2, 6, 2);
    run(0, 3);
    run(0, 0);

    // Stop in P1 with endless repeats, then start+stop together while idle.
    cfg_all(10, 2, 2, 20, 0);
    run(5, 0);
    sb.push_back(idle_exp(cyc + 1, m_last_rep));
    sb.push_back(idle_exp(cyc + 2, m_last_rep));
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tick();

    // All zero: one-cycle periods, rep_cnt counting and wrapping.
    cfg_all(0, 0, 0, 0, 0);
    run(40, 0);

    // Reserved address is ignored.
    cfg_all(1, 1, 1, 4, 2);
    cfg_write(5, 99, 1'b0);
    run(0, 0);

    // Randomized short configurations run to completion.
    for (int i = 0; i < 10; i++) begin
      cfg_all($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 12), $urandom_range(1, 3));
      run(0, 0);
    end

    // Reset during GAP, then the default configuration must be back.
    cfg_all(3, 10, 2, 20, 0);
    rk = 6;
    base = cyc;
    for (int k = 1; k <= rk; k++) begin
      e = model_at(k); e.cyc = base + k; sb.push_back(e);
    end
    sb.push_back(idle_exp(base + rk + 1, 0));
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < base + rk) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_w1 = 30; m_d = 200; m_w2 = 60; m_per = 200000; m_rep = 0; m_last_rep = 0;
    tick();
    run(300, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
